// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: CPU write port,
// video fetch port and the single-port VRAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req, rd_addr, mem_rdata,
    input  wr_ready, rd_data, rd_valid,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req, rd_addr, mem_rdata,
    output wr_ready, rd_data, rd_valid,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads win,
// buffered CPU writes drain when fetch is idle.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_100m,
  input  logic                        btn_rst,
  vram_arbiter_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } gnt_t;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rd_s1;
  logic              rd_s2;
  gnt_t              gnt;

  assign empty        = (count == '0);
  assign bus.wr_ready = (count < DEPTH);
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = (gnt == GNT_WR);
  assign fifo_count   = count;

  // Grant: fetch has strict priority, writes only when fetch idle
  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      bus.rd_req:           gnt = GNT_RD;
      !bus.rd_req && !empty: gnt = GNT_WR;
      default:              gnt = GNT_NONE;
    endcase
  end

  // Write-buffer storage; contents need no reset
  always_ff @(posedge clk_100m) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.wr_addr;
      q_data[wr_ptr] <= bus.wr_data;
    end
  end

  // Write-buffer pointers, occupancy and sticky drop flag
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.wr_valid && !bus.wr_ready)
        overflow <= 1'b1;
    end
  end

  // Registered VRAM port; address/data hold when idle
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= (gnt != GNT_NONE);
      bus.mem_we <= (gnt == GNT_WR);
      if (gnt == GNT_RD)
        bus.mem_addr <= bus.rd_addr;
      if (gnt == GNT_WR) begin
        bus.mem_addr  <= q_addr[rd_ptr];
        bus.mem_wdata <= q_data[rd_ptr];
      end
    end
  end

  // Read return pipe: grant -> mem access -> rdata -> rd_valid
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      rd_s1        <= 1'b0;
      rd_s2        <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      rd_s1        <= (gnt == GNT_RD);
      rd_s2        <= rd_s1;
      bus.rd_valid <= rd_s2;
      if (rd_s2)
        bus.rd_data <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table plus
// hand sequences, memory port scoreboarded.
module tb_vram_arbiter;
  typedef struct {
    logic        rd;
    logic [15:0] ra;
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] rexp;
    int          wlat;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wexp_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        mon_on = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] ram [256];

  vec_t        tbl [24];
  wexp_t       wq [$];
  rexp_t       rq [$];
  logic [15:0] raq [$];
  wexp_t       mw;
  rexp_t       mr;
  logic [15:0] ma;

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  vram_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_100m(clk),
    .btn_rst(rst),
    .bus(bus),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM model: preloaded with addr+0x100, 1-cycle read
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= 16'(i + 256);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en === 1'b1) begin
      if (bus.mem_we)
        ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [15:0] a,
                         input logic [15:0] d,
                         input int c);
    rexp_t r;
    r.data = d;
    r.cyc  = c;
    rq.push_back(r);
    raq.push_back(a);
  endtask

  task automatic push_wr(input logic [15:0] a,
                         input logic [15:0] d,
                         input int c);
    wexp_t w;
    w.addr = a;
    w.data = d;
    w.cyc  = c;
    wq.push_back(w);
  endtask

  function automatic vec_t mk(input logic rd,
                              input logic [15:0] ra,
                              input logic wr,
                              input logic [15:0] wa,
                              input logic [15:0] wd,
                              input int wlat,
                              input int cnt);
    vec_t v;
    v.rd   = rd;
    v.ra   = ra;
    v.wr   = wr;
    v.wa   = wa;
    v.wd   = wd;
    v.rexp = ra + 16'h100;
    v.wlat = wlat;
    v.cnt  = cnt;
    return v;
  endfunction

  // Scoreboard: every memory access and read return
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_write: got %0h/%0h want none",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", 64'(bus.mem_addr), 64'(mw.addr));
          chk("wr_data", 64'(bus.mem_wdata), 64'(mw.data));
          if (mw.cyc >= 0)
            chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
        end
      end
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) begin
        if (raq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_read: got %0h want none",
                   bus.mem_addr);
        end else begin
          ma = raq.pop_front();
          chk("rd_issue_addr", 64'(bus.mem_addr), 64'(ma));
        end
      end
      if (bus.rd_valid === 1'b1) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_rd_valid: got %0h want none",
                   bus.rd_data);
        end else begin
          mr = rq.pop_front();
          chk("rd_data", 64'(bus.rd_data), 64'(mr.data));
          chk("rd_cycle", 64'(cyc), 64'(mr.cyc));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 24; i++)
      tbl[i] = mk(0, 0, 0, 0, 0, -1, 0);
    tbl[0] = mk(0, 0, 1, 16'h0005, 16'h0032, 2, 1);
    for (int i = 0; i < 4; i++)
      tbl[4 + i] = mk(1, 16'h10 + 16'(i), 0, 0, 0, -1, 0);
    tbl[12] = mk(0, 0, 1, 16'h20, 16'hA1, 2, 1);
    tbl[13] = mk(0, 0, 1, 16'h21, 16'hA2, 2, 1);
    tbl[16] = mk(0, 0, 1, 16'h22, 16'hA3, 4, 1);
    tbl[17] = mk(1, 16'h40, 1, 16'h23, 16'hA4, 4, 2);
    tbl[18] = mk(1, 16'h41, 0, 0, 0, -1, 2);
    tbl[19] = mk(0, 0, 0, 0, 0, -1, 1);

    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;

    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("reset_outs%0d", i),
          64'({bus.wr_ready, bus.rd_valid, bus.rd_data,
               bus.mem_en, bus.mem_we, bus.mem_addr,
               bus.mem_wdata, fifo_count, overflow}),
          64'({1'b1, 56'h0}));
    end

    foreach (tbl[i]) begin
      bus.rd_req   = tbl[i].rd;
      bus.rd_addr  = tbl[i].ra;
      bus.wr_valid = tbl[i].wr;
      bus.wr_addr  = tbl[i].wa;
      bus.wr_data  = tbl[i].wd;
      if (tbl[i].rd)
        push_rd(tbl[i].ra, tbl[i].rexp, cyc + 3);
      if (tbl[i].wr)
        push_wr(tbl[i].wa, tbl[i].wd,
                tbl[i].wlat < 0 ? -1 : cyc + tbl[i].wlat);
      tick();
      chk($sformatf("count_row%0d", i),
          64'(fifo_count), 64'(tbl[i].cnt));
    end
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (4) tick();

    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h50;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("ovf_ready%0d", i),
          64'(bus.wr_ready), 64'(i < 8));
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 16'h60 + 16'(i);
      bus.wr_data  = 16'hB0 + 16'(i);
      push_rd(16'h50, 16'h150, cyc + 3);
      if (i < 8)
        push_wr(bus.wr_addr, bus.wr_data, -1);
      tick();
    end
    chk("full_count", 64'(fifo_count), 64'd8);
    chk("full_ready", 64'(bus.wr_ready), 64'd0);
    chk("ovf_set", 64'(overflow), 64'd1);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h69;
    bus.wr_data  = 16'hEE;
    tick();
    bus.wr_valid = 1'b0;
    chk("full_pop_nopush", 64'(fifo_count), 64'd7);
    repeat (10) tick();
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    bus.rd_req  = 1'b1;
    bus.rd_addr = 16'h70;
    for (int j = 0; j < 3; j++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 16'h90 + 16'(j);
      bus.wr_data  = 16'hC0 + 16'(j);
      if (j == 0)
        push_rd(16'h70, 16'h170, cyc + 3);
      else
        raq.push_back(16'h70);
      tick();
    end
    chk("queued3", 64'(fifo_count), 64'd3);
    bus.rd_req   = 1'b0;
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_mem",
        64'({bus.mem_en, bus.rd_valid, bus.rd_data}),
        64'd0);
    repeat (8) tick();
    chk("post_rst_count", 64'(fifo_count), 64'd0);

    chk("wq_left", 64'(wq.size()), 64'd0);
    chk("rq_left", 64'(rq.size()), 64'd0);
    chk("raq_left", 64'(raq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous VRAM between two requesters:
  - CPU write path from the EBI decoder, buffered in an internal FIFO.
  - Video pixel-fetch read path, which has strict priority.
- Sits between the EBI bus interface and the VGA scan-out logic inside display_driver.
- Buffered CPU writes drain whenever the fetch path is idle, e.g. during blanking.

Parameters:
- ADDR_W, 16, VRAM address width.
- DATA_W, 16, VRAM data width.
- FIFO_DEPTH, 8, write-buffer depth in entries; power of two, at least 2.

Ports:
- clk_100m  in  1  system clock; all logic on the rising edge.
- btn_rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  CPU write request.
- wr_addr  in  ADDR_W  CPU write address.
- wr_data  in  DATA_W  CPU write data.
- wr_ready  out  1  FIFO can accept a write.
- rd_req  in  1  video fetch read request.
- rd_addr  in  ADDR_W  fetch address.
- rd_data  out  DATA_W  fetched data.
- rd_valid  out  1  rd_data valid this cycle.
- mem_en  out  1  VRAM enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data; valid 1 cycle after mem_en with mem_we=0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (btn_rst=1 at an edge):
  - All outputs go to 0; wr_ready is 1 from the first cycle after reset.
  - FIFO is emptied and the read pipeline is flushed.
  - overflow is cleared.
  - Reset mid-operation discards queued writes and any in-flight read; no rd_valid is produced for that read.
- FIFO push:
  - Occurs when wr_valid && wr_ready.
  - wr_ready = (fifo_count < FIFO_DEPTH), using the registered count.
  - When full, wr_ready stays 0 even if a pop happens in the same cycle.
- Dropped writes: wr_valid && !wr_ready discards the write and sets overflow. overflow holds until reset.
- Grant, decided each cycle from inputs and registered state:
  - GNT_RD if rd_req=1.
  - Else GNT_WR if FIFO is non-empty; this pops the head entry.
  - Else GNT_NONE.
- Memory port (all mem_* outputs registered):
  - GNT_RD in cycle N: cycle N+1 drives mem_en=1, mem_we=0, mem_addr=rd_addr.
  - GNT_WR in cycle N: cycle N+1 drives mem_en=1, mem_we=1, mem_addr and mem_wdata from the FIFO head.
  - GNT_NONE: mem_en=0, mem_we=0; address and data hold their previous values.
- Read latency:
  - rd_valid=1 and rd_data=mem_rdata are registered in cycle N+3 for rd_req sampled in cycle N.
  - The path is fully pipelined: back-to-back rd_req gives back-to-back rd_valid, in order.
  - rd_data holds its value when rd_valid=0.
- Simultaneous push and pop: allowed; fifo_count is unchanged. Push and pop on an empty FIFO in the same cycle is not a bypass: the entry is popped at the earliest the following cycle.
- Ordering:
  - CPU writes reach VRAM in acceptance order.
  - A read may return stale data if a write to the same address is still queued. This is permitted; no forwarding.
- Starvation: writes wait indefinitely while rd_req=1. rd_req is never stalled and has no ready signal.
- Pointers: wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then idle 5 cycles -> every output 0 except wr_ready=1; fifo_count=0; mem_en never asserted.
- Single write (addr 0x0005, data 0x0032) with rd_req=0 -> mem_en=1, mem_we=1, mem_addr=0x0005, mem_wdata=0x0032 exactly 2 cycles after the accepting edge; fifo_count back to 0.
- rd_req held high 4 cycles with addr 0x10..0x13, RAM model preloaded addr+0x100 -> rd_valid high 4 consecutive cycles starting 3 cycles after the first request; rd_data 0x110..0x113 in order.
- rd_req held high while 9 writes are issued with FIFO_DEPTH=8 -> 8 accepted, wr_ready=0 after the 8th, 9th dropped, overflow=1; after rd_req drops, 8 writes appear on the memory port in order and no write to the 9th address occurs.
- Write queued plus rd_req asserted in the same cycle -> read issued first; write issued the cycle after rd_req deasserts.
- btn_rst asserted 1 cycle after an rd_req with 3 writes queued -> no rd_valid afterwards; fifo_count=0; queued writes never reach mem_*.
